// File: rtl/sign_sched_pkg.sv
// Decoder-wide constants and types shared by the sign scheduler, the
// unscrambler and the position decoder.
package sign_sched_pkg;

  localparam int MB_MAX_COEF = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sign_sched_state_t;

endpackage

// File: rtl/sign_sched_inflight_cnt.sv
// Up/down counter of macroblocks issued but not yet retired by the unscrambler,
// with a below-limit compare and an underflow indication.
module inflight_cnt #(
  parameter int LIMIT = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         below_limit_o,
  output logic         underflow_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A retire pulse with nothing in flight (and no issue to cancel it) is dropped.
  assign underflow_o   = dec_i & ~inc_i & (count_q == '0);
  assign below_limit_o = (count_q < W'(LIMIT));
  assign count_o       = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sign_sched.sv
// Sign-bit sequencer: takes a per-MB sign count, pulls that many bits from the
// bitstream reader one per cycle and hands them to the coefficient unscrambler.
module sign_sched
  import sign_sched_pkg::*;
#(
  parameter int  MAX_INFLIGHT = 2,
  parameter int  CNT_W        = 7,
  localparam int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic             rst,
  input  logic             flush,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  input  logic             bs_bit,
  input  logic             bs_valid,
  output logic             bs_rd,
  input  logic             out_full,
  input  logic             unscr_mb_done,
  output logic             sign_in,
  output logic             sign_en,
  output logic             zero_mb,
  output logic [INF_W-1:0] inflight,
  output logic             busy,
  output logic             err
);

  sign_sched_state_t state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              sign_in_q, sign_in_d;
  logic              sign_en_q, sign_en_d;
  logic              zero_mb_q, zero_mb_d;
  logic              err_q, err_d;

  logic accept;
  logic cnt_zero;
  logic cnt_over;
  logic last_bit;
  logic below_limit;
  logic underflow;

  // Handshakes are suppressed while rst is asserted so no bit is consumed by an
  // MB that the same edge is about to abandon.
  assign cnt_ready = rst & clk_en & ~flush & (state_q == IDLE) & below_limit;
  assign bs_rd     = rst & clk_en & ~flush & (state_q == ISSUE) & bs_valid & ~out_full;
  assign accept    = cnt_valid & cnt_ready;
  assign cnt_zero  = (cnt_in == '0);
  assign cnt_over  = (cnt_in > CNT_W'(MB_MAX_COEF));
  assign last_bit  = bs_rd & (remaining_q == CNT_W'(1));

  inflight_cnt #(
    .LIMIT(MAX_INFLIGHT),
    .W    (INF_W)
  ) u_inflight (
    .clk          (clk),
    .rst          (rst),
    .en_i         (clk_en),
    .clr_i        (flush),
    .inc_i        (last_bit),
    .dec_i        (unscr_mb_done),
    .count_o      (inflight),
    .below_limit_o(below_limit),
    .underflow_o  (underflow)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sign_in_q   <= 1'b0;
      sign_en_q   <= 1'b0;
      zero_mb_q   <= 1'b0;
      err_q       <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sign_in_q   <= sign_in_d;
      sign_en_q   <= sign_en_d;
      zero_mb_q   <= zero_mb_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept && !cnt_zero) state_d = ISSUE;
        ISSUE:   if (last_bit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    sign_in_d   = sign_in_q;
    sign_en_d   = 1'b0;
    zero_mb_d   = 1'b0;
    err_d       = err_q;
    if (flush) begin
      remaining_d = '0;
      err_d       = 1'b0;
    end else begin
      sign_en_d = bs_rd;
      zero_mb_d = accept & cnt_zero;
      if (bs_rd) sign_in_d = bs_bit;
      // Oversized counts are clamped to a full macroblock and flagged.
      if (accept) begin
        remaining_d = cnt_over ? CNT_W'(MB_MAX_COEF) : cnt_in;
      end else if (bs_rd) begin
        remaining_d = remaining_q - CNT_W'(1);
      end
      if ((accept && cnt_over) || underflow) err_d = 1'b1;
    end
  end

  assign sign_in = sign_in_q;
  assign sign_en = sign_en_q;
  assign zero_mb = zero_mb_q;
  assign err     = err_q;
  assign busy    = (state_q == ISSUE);

endmodule

// File: doc/sign_sched.md
# sign_sched

Sequencing controller for the coefficient unscrambler. Per macroblock it accepts a sign-bit count from the run/position decoder, pulls exactly that many sign bits one per cycle from the bitstream reader, and drives them into the unscrambler's `sign_in`/`sign_en`. It stalls on downstream backpressure and caps how many macroblocks of signs may run ahead of the unscrambler's completion.

## Interface
Parameters:
- `MAX_INFLIGHT`, default 2: macroblocks issued but not yet reported done by the unscrambler. Legal range is 1..7.
- `CNT_W`, default 7: width of the per-MB sign count. Legal counts are 0..64.

Ports:
- `clk` in 1: clock.
- `clk_en` in 1: global clock enable. When low, all state and registered outputs hold.
- `rst` in 1: reset, synchronous, active-low.
- `flush` in 1: synchronous abort pulse, sampled only when `clk_en`=1.
- `cnt_in` in CNT_W: sign-bit count for the next MB.
- `cnt_valid` in 1: `cnt_in` is valid.
- `cnt_ready` out 1: count accepted this cycle. Combinational.
- `bs_bit` in 1: current head bit of the bitstream reader.
- `bs_valid` in 1: `bs_bit` is valid.
- `bs_rd` out 1: consume the head bit. Combinational.
- `out_full` in 1: unscrambler output FIFO full. Stall.
- `unscr_mb_done` in 1: one-cycle pulse from the unscrambler when an MB is written out.
- `sign_in` out 1: sign bit to the unscrambler. Registered.
- `sign_en` out 1: `sign_in` is valid. Registered.
- `zero_mb` out 1: pulse when a count of 0 is accepted. Registered.
- `inflight` out $clog2(MAX_INFLIGHT+1): current in-flight MB count.
- `busy` out 1: state is ISSUE.
- `err` out 1: sticky error flag. Cleared only by `rst` or `flush`.

## Operation
- States are IDLE and ISSUE. Register `remaining` is CNT_W wide.
- Counter `inflight` saturates nowhere: overflow is prevented by the IDLE gate below.

IDLE:
- `cnt_ready` = `clk_en` & (`inflight` < MAX_INFLIGHT) & !`flush`.
- On acceptance with `cnt_in`=0: stay in IDLE, pulse `zero_mb`, leave `inflight` unchanged.
- On acceptance with `cnt_in` in 1..64: load `remaining`=`cnt_in` and go to ISSUE.
- On acceptance with `cnt_in`>64: set `err`, treat the count as 64.

ISSUE:
- `bs_rd` = `clk_en` & `bs_valid` & !`out_full` & !`flush`.
- On each `bs_rd`:
  - Register `sign_in`<=`bs_bit` and `sign_en`<=1.
  - Decrement `remaining`.
  - When `remaining` was 1: increment `inflight` and return to IDLE.
- On any `clk_en` cycle without `bs_rd`: `sign_en`<=0.
- `cnt_ready`=0 throughout ISSUE.

Inflight accounting:
- `inflight` decrements on `unscr_mb_done`.
- An increment and a decrement in the same cycle leave it unchanged.
- `unscr_mb_done` with `inflight`=0 and no increment that cycle: ignored, set `err`.

Flush (when `clk_en`=1):
- Go to IDLE.
- `remaining`, `inflight` and `err` go to 0.
- `sign_en`<=0, `zero_mb`<=0.
- `bs_rd`=0 and `cnt_ready`=0 in the flush cycle.
- Flush has priority over every other event.

Reset (`rst`=0 at a clock edge, independent of `clk_en`):
- State IDLE.
- `remaining`=0, `inflight`=0, `err`=0.
- `sign_in`=0, `sign_en`=0, `zero_mb`=0.
- Reset mid-ISSUE abandons the MB with no further `bs_rd`.

## Timing
- `bs_rd` → `sign_en`/`sign_in`: 1 cycle latency.
- Back-to-back bit handling:
  - With `bs_valid`=1 and `out_full`=0, an N-bit MB produces N consecutive `sign_en` cycles.
  - The first `bs_rd` occurs on the cycle after count acceptance.
- Minimum inter-MB gap is 1 IDLE cycle, so the next count is accepted on the cycle after the final `bs_rd`.
- `out_full` and `bs_valid` act combinationally on `bs_rd` in the same cycle. No bit is lost or duplicated on a stall.
- `inflight` is registered: an MB completing in cycle t is visible to `cnt_ready` in cycle t+1.
- `zero_mb` and `sign_en` are single-cycle pulses per event.

## Structure
- Shared decoder package holds:
  - `MB_MAX_COEF`=64.
  - Enum `sign_sched_state_t` = {IDLE, ISSUE}.
- The package is shared with the unscrambler and position decoder.
- One sub-module, `inflight_cnt`:
  - Up/down counter with simultaneous inc/dec.
  - Limit compare output.
  - Underflow flag.
- Everything else stays in `sign_sched`.

## Test plan
- **Single MB:** after reset, count 5, `bs_valid`=1, bits 1,0,1,1,0.
  - `cnt_ready` pulses once; 5 `bs_rd` cycles.
  - `sign_en` high 5 consecutive cycles, delayed by 1, with `sign_in`=1,0,1,1,0.
  - `inflight`=1 afterward.
- **Inflight cap:** counts 3,3,3 with `MAX_INFLIGHT`=2 and no `unscr_mb_done`.
  - Third count is held with `cnt_ready`=0.
  - One `unscr_mb_done` pulse → third count accepted the next cycle; `inflight` goes 2→1→2.
- **Stalls:** count 64; toggle `out_full` every 3 cycles; drop `bs_valid` randomly.
  - Exactly 64 `bs_rd` and 64 `sign_en` cycles.
  - Bit order preserved; no `bs_rd` while `out_full`=1.
- **Boundary events:**
  - Count 0 → `zero_mb` single pulse, `inflight` unchanged, no `bs_rd`.
  - Count 65 → `err`=1 and 64 bits issued.
  - `unscr_mb_done` at `inflight`=0 → `err`=1, `inflight` stays 0.
- **Simultaneous events:** final `bs_rd` of an MB coincides with `unscr_mb_done` at `inflight`=1 → `inflight` stays 1.
- **Abort:**
  - `flush` at `remaining`=10 → next cycle IDLE, `inflight`=0, `err`=0, `sign_en`=0.
  - `rst` low mid-ISSUE → all outputs zero.
  - `clk_en`=0 for 4 cycles mid-ISSUE → state and outputs frozen, `bs_rd`=0.
